// File: rtl/cam_capture.sv
// cam_capture: captures a DVP-style 8-bit camera stream (pclk/href/vsync/data)
// into the system clock domain and emits RGB565 pixels with their column/row.
// All camera inputs are oversampled on clk, which must run at least 4x pclk.
// Optional line/frame length checking is built only when the macro
// CAM_CAPTURE_LINECHK_EN is defined; otherwise line_err is tied low.
module cam_capture #(
    parameter int H_PIXELS = 640,
    parameter int V_LINES  = 480
) (
    input  logic        clk,
    input  logic        res,
    input  logic        pclk,
    input  logic        href,
    input  logic        vsync,
    input  logic [7:0]  data,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        frame_start,
    output logic        frame_end,
    output logic        busy,
    output logic        line_err
);

    typedef enum logic [1:0] {
        S_SYNC  = 2'd0,
        S_FRAME = 2'd1,
        S_LINE  = 2'd2
    } state_t;

    // Synchronizer chains: [0],[1] are the 2-flop synchronizer, [2] is history.
    // href is only ever sampled at a pclk event, so it needs no history flop.
    logic [2:0]      pclk_sh_reg;
    logic [2:0]      vsync_sh_reg;
    logic [1:0]      href_sh_reg;
    logic [1:0][7:0] data_sh_reg;

    logic pclk_evt;
    logic vsync_rise;
    logic vsync_fall;
    logic href_s;
    logic [7:0] data_s;

    state_t      state_reg, state_next;
    logic [9:0]  x_reg, x_next;
    logic [8:0]  y_reg, y_next;
    logic        phase_reg, phase_next;
    logic [7:0]  hi_reg, hi_next;
    logic        started_reg, started_next;

    // Stage registers between the FSM and the output registers.
    logic        st_valid_reg, st_valid_next;
    logic [15:0] st_data_reg, st_data_next;
    logic [9:0]  st_x_reg, st_x_next;
    logic [8:0]  st_y_reg, st_y_next;
    logic        st_fs_reg, st_fs_next;
    logic        st_fe_reg, st_fe_next;

`ifdef CAM_CAPTURE_LINECHK_EN
    localparam logic [31:0] H_CHK = 32'(H_PIXELS);
    localparam logic [31:0] V_CHK = 32'(V_LINES);
    logic err_reg, err_next;
`endif

    assign pclk_evt   = pclk_sh_reg[1] & ~pclk_sh_reg[2];
    assign vsync_rise = vsync_sh_reg[1] & ~vsync_sh_reg[2];
    assign vsync_fall = ~vsync_sh_reg[1] & vsync_sh_reg[2];
    assign href_s     = href_sh_reg[1];
    assign data_s     = data_sh_reg[1];
    assign busy       = (state_reg != S_SYNC);

    // Bring the camera signals into the clk domain; data tracks pclk stage for stage.
    always_ff @(posedge clk) begin
        if (res) begin
            pclk_sh_reg  <= '0;
            vsync_sh_reg <= '0;
            href_sh_reg  <= '0;
            data_sh_reg  <= '0;
        end else begin
            pclk_sh_reg  <= {pclk_sh_reg[1:0], pclk};
            vsync_sh_reg <= {vsync_sh_reg[1:0], vsync};
            href_sh_reg  <= {href_sh_reg[0], href};
            data_sh_reg  <= {data_sh_reg[0], data};
        end
    end

    // FSM state, line/pixel counters and the pixel stage register.
    always_ff @(posedge clk) begin
        if (res) begin
            state_reg    <= S_SYNC;
            x_reg        <= '0;
            y_reg        <= '0;
            phase_reg    <= 1'b0;
            hi_reg       <= '0;
            started_reg  <= 1'b0;
            st_valid_reg <= 1'b0;
            st_data_reg  <= '0;
            st_x_reg     <= '0;
            st_y_reg     <= '0;
            st_fs_reg    <= 1'b0;
            st_fe_reg    <= 1'b0;
`ifdef CAM_CAPTURE_LINECHK_EN
            err_reg      <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            x_reg        <= x_next;
            y_reg        <= y_next;
            phase_reg    <= phase_next;
            hi_reg       <= hi_next;
            started_reg  <= started_next;
            st_valid_reg <= st_valid_next;
            st_data_reg  <= st_data_next;
            st_x_reg     <= st_x_next;
            st_y_reg     <= st_y_next;
            st_fs_reg    <= st_fs_next;
            st_fe_reg    <= st_fe_next;
`ifdef CAM_CAPTURE_LINECHK_EN
            err_reg      <= err_next;
`endif
        end
    end

    // Next-state, byte pairing and frame/line bookkeeping.
    always_comb begin
        state_next    = state_reg;
        x_next        = x_reg;
        y_next        = y_reg;
        phase_next    = phase_reg;
        hi_next       = hi_reg;
        started_next  = started_reg;
        st_valid_next = 1'b0;
        st_data_next  = st_data_reg;
        st_x_next     = st_x_reg;
        st_y_next     = st_y_reg;
        st_fs_next    = 1'b0;
        st_fe_next    = 1'b0;
`ifdef CAM_CAPTURE_LINECHK_EN
        err_next      = err_reg;
`endif
        case (state_reg)
            S_SYNC: begin
                if (vsync_fall) begin
                    state_next   = S_FRAME;
                    y_next       = '0;
                    st_fs_next   = 1'b1;
                    started_next = 1'b1;
`ifdef CAM_CAPTURE_LINECHK_EN
                    err_next     = 1'b0;
`endif
                end
            end
            S_FRAME: begin
                if (vsync_rise) begin
                    state_next = S_SYNC;
                    st_fe_next = started_reg;
`ifdef CAM_CAPTURE_LINECHK_EN
                    if ({23'd0, y_reg} != V_CHK) err_next = 1'b1;
`endif
                end else if (pclk_evt && href_s) begin
                    // The event that opens the line already carries the phase-0
                    // byte, so it is latched here and the phase moves on to 1.
                    state_next = S_LINE;
                    x_next     = '0;
                    hi_next    = data_s;
                    phase_next = 1'b1;
                end
            end
            S_LINE: begin
                if (vsync_rise) begin
                    // Aborted line: partial pixel dropped, row count left as is.
                    state_next = S_SYNC;
                    st_fe_next = started_reg;
                    phase_next = 1'b0;
`ifdef CAM_CAPTURE_LINECHK_EN
                    if ({23'd0, y_reg} != V_CHK) err_next = 1'b1;
`endif
                end else if (pclk_evt) begin
                    if (href_s) begin
                        if (!phase_reg) begin
                            hi_next    = data_s;
                            phase_next = 1'b1;
                        end else begin
                            st_valid_next = 1'b1;
                            st_data_next  = {hi_reg, data_s};
                            st_x_next     = x_reg;
                            st_y_next     = y_reg;
                            phase_next    = 1'b0;
                            if (x_reg != 10'h3FF) x_next = x_reg + 10'd1;
                        end
                    end else begin
                        // End of line; an unpaired trailing byte is simply dropped.
                        state_next = S_FRAME;
                        phase_next = 1'b0;
                        if (y_reg != 9'h1FF) y_next = y_reg + 9'd1;
`ifdef CAM_CAPTURE_LINECHK_EN
                        if ({22'd0, x_reg} != H_CHK) err_next = 1'b1;
`endif
                    end
                end
            end
            default: state_next = S_SYNC;
        endcase
    end

    // Output register stage.
    always_ff @(posedge clk) begin
        if (res) begin
            pix_data    <= '0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
`ifdef CAM_CAPTURE_LINECHK_EN
            line_err    <= 1'b0;
`endif
        end else begin
            pix_data    <= st_data_reg;
            pix_valid   <= st_valid_reg;
            pix_x       <= st_x_reg;
            pix_y       <= st_y_reg;
            frame_start <= st_fs_reg;
            frame_end   <= st_fe_reg;
`ifdef CAM_CAPTURE_LINECHK_EN
            line_err    <= err_reg;
`endif
        end
    end

`ifndef CAM_CAPTURE_LINECHK_EN
    assign line_err = 1'b0;
`endif

endmodule

// File: tb/tb_cam_capture.sv
// Testbench for cam_capture: a camera model drives directed lines/frames and
// pushes each expected pixel into a scoreboard; a monitor pops and compares
// whenever pix_valid is seen. Frame strobes are counted and compared.
module tb_cam_capture;

    localparam int HP = 8;
    localparam int VL = 3;
`ifdef CAM_CAPTURE_LINECHK_EN
    localparam logic LCHK = 1'b1;
`else
    localparam logic LCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        pclk = 1'b0;
    logic        res;
    logic        href;
    logic        vsync;
    logic [7:0]  data;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        frame_start;
    logic        frame_end;
    logic        busy;
    logic        line_err;

    typedef struct {
        logic [15:0] d;
        logic [9:0]  x;
        logic [8:0]  y;
        longint      t;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          passes = 0;
    int          fs_cnt = 0;
    int          fe_cnt = 0;
    int          exp_fs = 0;
    int          exp_fe = 0;
    int          mx = 0;
    int          my = 0;
    logic [7:0]  hi_b = 8'd0;

    cam_capture #(.H_PIXELS(HP), .V_LINES(VL)) dut (
        .clk(clk), .res(res), .pclk(pclk), .href(href), .vsync(vsync),
        .data(data), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start),
        .frame_end(frame_end), .busy(busy), .line_err(line_err)
    );

    always #5 clk = ~clk;
    initial begin
        #2;
        forever #30 pclk = ~pclk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish before time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Sample time of pix_valid: 4th clk posedge after the pclk rise, read on the following negedge.
    function automatic longint exp_time(input longint t);
        return 5 + 10 * ((t - 5) / 10 + 1) + 35;
    endfunction

    // Monitor: pops the scoreboard for every pixel and checks strobe exclusivity.
    always @(negedge clk) begin
        if (!res) begin
            if (pix_valid || frame_start || frame_end)
                check("strobe_excl", 64'(pix_valid) + 64'(frame_start) + 64'(frame_end), 64'd1);
            if (frame_start) fs_cnt++;
            if (frame_end) fe_cnt++;
            if (pix_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL pix_unexpected: got data=%h x=%0d y=%0d expected no pixel",
                             pix_data, pix_x, pix_y);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("pix", 64'({pix_data, pix_x, pix_y}), 64'({e.d, e.x, e.y}));
                    check("pix_latency", 64'($time), 64'(exp_time(e.t)));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge pclk);
            href = 1'b0;
        end
    endtask

    task automatic byte_out(input int i, input bit en);
        @(negedge pclk);
        href = 1'b1;
        data = i[7:0];
        @(posedge pclk);
        if (i[0] == 1'b0) begin
            hi_b = data;
        end else if (en) begin
            exp_t e;
            e.d = {hi_b, data};
            e.x = 10'((mx > 1023) ? 1023 : mx);
            e.y = 9'((my > 511) ? 511 : my);
            e.t = longint'($time);
            sb.push_back(e);
            mx++;
        end
    endtask

    task automatic send_line(input int n, input bit en);
        mx = 0;
        for (int i = 0; i < n; i++) byte_out(i, en);
        @(negedge pclk);
        href = 1'b0;
        if (en) my++;
        idle(3);
    endtask

    task automatic vs_rise(input bit fe_exp);
        @(negedge pclk);
        vsync = 1'b1;
        href = 1'b0;
        if (fe_exp) exp_fe++;
        idle(3);
        check("frame_end_cnt", 64'(fe_cnt), 64'(exp_fe));
        check("busy_after_vsync_rise", 64'(busy), 64'd0);
    endtask

    task automatic vs_fall();
        @(negedge pclk);
        vsync = 1'b0;
        href = 1'b0;
        my = 0;
        exp_fs++;
        idle(3);
        check("frame_start_cnt", 64'(fs_cnt), 64'(exp_fs));
        check("busy_in_frame", 64'(busy), 64'd1);
    endtask

    initial begin
        res = 1'b1;
        href = 1'b0;
        vsync = 1'b0;
        data = 8'd0;
        repeat (4) @(negedge clk);
        check("reset_outputs",
              64'({pix_data, pix_valid, pix_x, pix_y, frame_start, frame_end, busy, line_err}), 64'd0);
        res = 1'b0;

        // Frame already in progress at reset release: ignored; the first vsync rise has no frame_end.
        idle(2);
        send_line(16, 1'b0);
        vs_rise(1'b0);

        // Nominal frame: VL lines of 2*HP bytes.
        vs_fall();
        idle(10);
        repeat (VL) send_line(2 * HP, 1'b1);
        vs_rise(1'b1);
        check("line_err_nominal", 64'(line_err), 64'd0);

        // Odd-length line: trailing byte dropped, next line restarts at x=0.
        vs_fall();
        send_line(2 * HP + 1, 1'b1);
        send_line(2 * HP, 1'b1);
        send_line(2 * HP, 1'b1);
        vs_rise(1'b1);

        // Abort: vsync rises after 100 bytes of line 5.
        vs_fall();
        repeat (5) send_line(4, 1'b1);
        mx = 0;
        for (int i = 0; i < 100; i++) byte_out(i, 1'b1);
        @(negedge pclk);
        vsync = 1'b1;
        data = 8'd100;
        exp_fe++;
        for (int i = 101; i < 104; i++) byte_out(i, 1'b0);
        @(negedge pclk);
        href = 1'b0;
        idle(3);
        check("frame_end_abort", 64'(fe_cnt), 64'(exp_fe));
        check("busy_after_abort", 64'(busy), 64'd0);
        send_line(16, 1'b0);

        // Short line sets line_err when checking is built; cleared on next frame_start.
        vs_fall();
        send_line(2 * HP, 1'b1);
        send_line(2 * HP - 2, 1'b1);
        check("line_err_short_line", 64'(line_err), 64'(LCHK));
        send_line(2 * HP, 1'b1);
        vs_rise(1'b1);
        check("line_err_at_frame_end", 64'(line_err), 64'(LCHK));
        vs_fall();
        check("line_err_cleared", 64'(line_err), 64'd0);

        // Mid-line reset.
        send_line(4, 1'b1);
        mx = 0;
        for (int i = 0; i < 8; i++) byte_out(i, 1'b1);
        byte_out(8, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        check("midline_reset_outputs",
              64'({pix_data, pix_valid, pix_x, pix_y, frame_start, frame_end, busy, line_err}), 64'd0);
        for (int i = 9; i < 16; i++) byte_out(i, 1'b0);
        @(negedge pclk);
        href = 1'b0;
        idle(3);
        send_line(16, 1'b0);
        vs_rise(1'b0);

        // Recovery after a fresh vsync fall, plus pix_x saturation on a long line.
        vs_fall();
        send_line(4, 1'b1);
        send_line(2050, 1'b1);
        vs_rise(1'b1);

        idle(5);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
